// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one RV32I load/store at a time toward a word-addressed memory.
// Sub-word stores are read-modify-write; loads are sign/zero extended.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        legal, misaligned, out_of_range, fault;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] store_data;

  // Request decode works on the live inputs; it is only consumed on accept.
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_we;
      default:                legal = 1'b0;
    endcase
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS_W;
    fault        = !legal || misaligned || out_of_range;
  end

  always_comb begin
    ld_byte = mem_RD[7:0];
    case (addr_q[1:0])
      2'd0: ld_byte = mem_RD[7:0];
      2'd1: ld_byte = mem_RD[15:8];
      2'd2: ld_byte = mem_RD[23:16];
      2'd3: ld_byte = mem_RD[31:24];
      default: ld_byte = mem_RD[7:0];
    endcase
    ld_half   = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    load_data = mem_RD;
    case (funct3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = mem_RD;
    endcase
  end

  always_comb begin
    store_data = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        store_data = word_q;
        case (addr_q[1:0])
          2'd0: store_data[7:0]   = wdata_q[7:0];
          2'd1: store_data[15:8]  = wdata_q[7:0];
          2'd2: store_data[23:16] = wdata_q[7:0];
          2'd3: store_data[31:24] = wdata_q[7:0];
          default: store_data = word_q;
        endcase
      end
      2'b01: begin
        store_data = word_q;
        if (addr_q[1]) store_data[31:16] = wdata_q[15:0];
        else           store_data[15:0]  = wdata_q[15:0];
      end
      default: store_data = wdata_q;
    endcase
  end

  // NOTE: every next-state variable takes its hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (fault) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        word_d = mem_RD;
        if (we_q) begin
          state_d = S_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = S_RESP;
        end
      end
      S_WRITE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_A      = ((state_q == S_READ) || (state_q == S_WRITE)) ? {2'b00, addr_q[31:2]} : '0;
  assign mem_WD     = (state_q == S_WRITE) ? store_data : '0;
  // The memory writes on the same edge that applies reset, so the enable is gated directly.
  assign mem_WE     = (state_q == S_WRITE) && !reset;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl with a behavioural word memory
// and a scoreboard of expected responses.
module tb_lsu_mem_ctrl;

  localparam int unsigned MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_WE;

  logic [31:0] mem [MEM_WORDS];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  int          wr_count;
  logic [31:0] last_wr_addr, last_wr_data;

  int n_checks;
  int n_fail;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
  } req_t;

  req_t sb[$];

  lsu_mem_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_WE     (mem_WE),
    .mem_RD     (mem_RD)
  );

  always #5 clk = ~clk;

  assign mem_RD = mem[mem_A[9:0]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_WE) begin
      mem[mem_A[9:0]] <= mem_WD;
      wr_count        <= wr_count + 1;
      last_wr_addr    <= mem_A;
      last_wr_data    <= mem_WD;
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drives one request and returns what the DUT answered plus the observed latency and write pulses.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat, output int writes);
    int w0;
    @(negedge clk);
    w0 = wr_count;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    writes = wr_count - w0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b expected 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b expected 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h expected 0", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got %b expected 0", resp_err); end
    n_checks++; if ({mem_WE, mem_A, mem_WD} !== 65'h0) begin n_fail++; $display("FAIL reset_mem_if got WE=%b A=%h WD=%h expected all 0", mem_WE, mem_A, mem_WD); end
  endtask

  task automatic test_loads();
    req_t tbl [4] = '{
      '{"lb_2c",     1'b0, 3'b000, 32'h2C,  32'h0, 32'h0000_0020, 1'b0, 2, 0},
      '{"lw_2c",     1'b0, 3'b010, 32'h2C,  32'h0, 32'h0000_0020, 1'b0, 2, 0},
      '{"lbu_2d",    1'b0, 3'b100, 32'h2D,  32'h0, 32'h0000_0000, 1'b0, 2, 0},
      '{"lw_lastwd", 1'b0, 3'b010, 32'hFFC, 32'h0, 32'h1234_5678, 1'b0, 2, 0}
    };
    logic [31:0] o_rd; logic o_err; int o_lat, o_wr; req_t e;
    preload(10'd11, 32'h0000_0020);
    preload(10'd1023, 32'h1234_5678);
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, o_rd, o_err, o_lat, o_wr);
      e = sb.pop_front();
      n_checks++; if (o_rd !== e.rdata) begin n_fail++; $display("FAIL %s rdata got %h expected %h", e.name, o_rd, e.rdata); end
      n_checks++; if (o_err !== e.err) begin n_fail++; $display("FAIL %s err got %b expected %b", e.name, o_err, e.err); end
      n_checks++; if (o_lat != e.lat) begin n_fail++; $display("FAIL %s latency got %0d expected %0d", e.name, o_lat, e.lat); end
      n_checks++; if (o_wr != e.writes) begin n_fail++; $display("FAIL %s writes got %0d expected %0d", e.name, o_wr, e.writes); end
    end
  endtask

  task automatic test_store_word();
    req_t tbl [5] = '{
      '{"sw_0",   1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 1},
      '{"lb_3",   1'b0, 3'b000, 32'h3, 32'h0,         32'hFFFF_FFDE, 1'b0, 2, 0},
      '{"lbu_3",  1'b0, 3'b100, 32'h3, 32'h0,         32'h0000_00DE, 1'b0, 2, 0},
      '{"lh_2",   1'b0, 3'b001, 32'h2, 32'h0,         32'hFFFF_DEAD, 1'b0, 2, 0},
      '{"lhu_0",  1'b0, 3'b101, 32'h0, 32'h0,         32'h0000_BEEF, 1'b0, 2, 0}
    };
    logic [31:0] o_rd; logic o_err; int o_lat, o_wr; req_t e;
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, o_rd, o_err, o_lat, o_wr);
      e = sb.pop_front();
      n_checks++; if (o_rd !== e.rdata) begin n_fail++; $display("FAIL %s rdata got %h expected %h", e.name, o_rd, e.rdata); end
      n_checks++; if (o_err !== e.err) begin n_fail++; $display("FAIL %s err got %b expected %b", e.name, o_err, e.err); end
      n_checks++; if (o_lat != e.lat) begin n_fail++; $display("FAIL %s latency got %0d expected %0d", e.name, o_lat, e.lat); end
      n_checks++; if (o_wr != e.writes) begin n_fail++; $display("FAIL %s writes got %0d expected %0d", e.name, o_wr, e.writes); end
      if (i == 0) begin
        n_checks++; if (last_wr_addr !== 32'h0) begin n_fail++; $display("FAIL sw_0 mem_A got %h expected 0", last_wr_addr); end
        n_checks++; if (last_wr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_0 mem_WD got %h expected deadbeef", last_wr_data); end
      end
    end
  endtask

  task automatic test_subword_store();
    req_t tbl [2] = '{
      '{"sb_5", 1'b1, 3'b000, 32'h5, 32'h0000_0011, 32'h0, 1'b0, 3, 1},
      '{"sh_6", 1'b1, 3'b001, 32'h6, 32'hABCD_2233, 32'h0, 1'b0, 3, 1}
    };
    logic [31:0] exp_wd [2] = '{32'hCAFE_11BE, 32'h2233_11BE};
    logic [31:0] o_rd; logic o_err; int o_lat, o_wr; req_t e;
    preload(10'd1, 32'hCAFE_BABE);
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, o_rd, o_err, o_lat, o_wr);
      e = sb.pop_front();
      n_checks++; if (o_rd !== e.rdata) begin n_fail++; $display("FAIL %s rdata got %h expected %h", e.name, o_rd, e.rdata); end
      n_checks++; if (o_err !== e.err) begin n_fail++; $display("FAIL %s err got %b expected %b", e.name, o_err, e.err); end
      n_checks++; if (o_lat != e.lat) begin n_fail++; $display("FAIL %s latency got %0d expected %0d", e.name, o_lat, e.lat); end
      n_checks++; if (o_wr != e.writes) begin n_fail++; $display("FAIL %s writes got %0d expected %0d", e.name, o_wr, e.writes); end
      n_checks++; if (last_wr_data !== exp_wd[i]) begin n_fail++; $display("FAIL %s mem_WD got %h expected %h", e.name, last_wr_data, exp_wd[i]); end
    end
    n_checks++; if (mem[1] !== 32'h2233_11BE) begin n_fail++; $display("FAIL subword_word1 got %h expected 223311be", mem[1]); end
  endtask

  task automatic test_faults();
    req_t tbl [5] = '{
      '{"lw_mis_2",   1'b0, 3'b010, 32'h2,    32'h0,         32'h0, 1'b1, 1, 0},
      '{"sh_mis_1",   1'b1, 3'b001, 32'h1,    32'h1234_5678, 32'h0, 1'b1, 1, 0},
      '{"f3_011",     1'b0, 3'b011, 32'h0,    32'h0,         32'h0, 1'b1, 1, 0},
      '{"st_f3_100",  1'b1, 3'b100, 32'h2C,   32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0},
      '{"lw_oob",     1'b0, 3'b010, 32'h1000, 32'h0,         32'h0, 1'b1, 1, 0}
    };
    logic [31:0] o_rd; logic o_err; int o_lat, o_wr; req_t e;
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, o_rd, o_err, o_lat, o_wr);
      e = sb.pop_front();
      n_checks++; if (o_rd !== e.rdata) begin n_fail++; $display("FAIL %s rdata got %h expected %h", e.name, o_rd, e.rdata); end
      n_checks++; if (o_err !== e.err) begin n_fail++; $display("FAIL %s err got %b expected %b", e.name, o_err, e.err); end
      n_checks++; if (o_lat != e.lat) begin n_fail++; $display("FAIL %s latency got %0d expected %0d", e.name, o_lat, e.lat); end
      n_checks++; if (o_wr != e.writes) begin n_fail++; $display("FAIL %s writes got %0d expected %0d", e.name, o_wr, e.writes); end
    end
  endtask

  task automatic test_backpressure();
    int w0, cyc;
    req_t e;
    sb.push_back('{"bp_lw_2c", 1'b0, 3'b010, 32'h2C, 32'h0, 32'h0000_0020, 1'b0, 2, 0});
    @(negedge clk);
    w0 = wr_count;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2C; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!resp_valid && cyc < 20) begin
      @(posedge clk); @(negedge clk); cyc++;
    end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h2C; req_wdata = 32'hFFFF_FFFF;
      n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err)
        begin n_fail++; $display("FAIL %s hold%0d got v=%b rd=%h err=%b expected v=1 rd=%h err=%b", e.name, k, resp_valid, resp_rdata, resp_err, e.rdata, e.err); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL %s hold%0d req_ready got %b expected 0", e.name, k, req_ready); end
      @(posedge clk); @(negedge clk);
    end
    req_valid = 1'b0; req_we = 1'b0; req_wdata = '0;
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%b ready=%b expected v=0 ready=1", resp_valid, req_ready); end
    n_checks++; if (wr_count != w0 || mem[11] !== 32'h0000_0020) begin n_fail++; $display("FAIL bp_ignored_req got writes=%0d word11=%h expected 0 and 00000020", wr_count - w0, mem[11]); end
  endtask

  task automatic test_reset_in_write();
    int w0;
    @(negedge clk);
    w0 = wr_count;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h2C; req_wdata = 32'h99;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_wdata = '0;
    n_checks++; if (mem_WE !== 1'b0 || mem_A !== 32'd11) begin n_fail++; $display("FAIL rw_read got WE=%b A=%h expected WE=0 A=b", mem_WE, mem_A); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_WE !== 1'b1 || mem_WD !== 32'h0000_0099) begin n_fail++; $display("FAIL rw_write got WE=%b WD=%h expected WE=1 WD=00000099", mem_WE, mem_WD); end
    reset = 1'b1;
    #1;
    n_checks++; if (mem_WE !== 1'b0) begin n_fail++; $display("FAIL rw_we_gated got %b expected 0", mem_WE); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0)
      begin n_fail++; $display("FAIL rw_reset_outs got ready=%b v=%b err=%b rd=%h expected 1 0 0 0", req_ready, resp_valid, resp_err, resp_rdata); end
    n_checks++; if ({mem_WE, mem_A, mem_WD} !== 65'h0) begin n_fail++; $display("FAIL rw_reset_mem_if got WE=%b A=%h WD=%h expected all 0", mem_WE, mem_A, mem_WD); end
    n_checks++; if (mem[11] !== 32'h0000_0020 || wr_count != w0) begin n_fail++; $display("FAIL rw_no_write got word11=%h writes=%0d expected 00000020 and 0", mem[11], wr_count - w0); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    wr_count = 0; last_wr_addr = '0; last_wr_data = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    test_reset();
    test_loads();
    test_store_word();
    test_subword_store();
    test_faults();
    test_backpressure();
    test_reset_in_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
